// File: rtl/aes_inv_key_generator_if.sv
// Key/control bus between the AES-128 inverse key generator
// and the inverse-round datapath that consumes its subkeys.
interface aes_inv_key_generator_if #(
  parameter int BLOCK_LENGTH = 128
);
  logic [BLOCK_LENGTH-1:0] key;
  logic                    key_load;
  logic                    key_next;
  logic [BLOCK_LENGTH-1:0] sub_key;
  logic [3:0]              round_index;
  logic                    key_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output key, key_load, key_next,
    input  sub_key, round_index, key_valid, busy, done
  );

  modport slave (
    input  key, key_load, key_next,
    output sub_key, round_index, key_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_generator.sv
// AES-128 round-key source for decryption: expands forward, then walks back.
// AES_EQUIV_INV_KEY_EN: present rounds 9..1 through InvMixColumns.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // entry i sits at bit 8*(255-i); 255-i is ~a for a byte
  assign y = SBOX[{~a, 3'b000} +: 8];
endmodule

module aes_inv_key_generator #(
  parameter int BLOCK_LENGTH = 128,
  parameter int NUM_ROUNDS   = 10
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_key_generator_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    SERVE
  } state_t;

  state_t                  state;
  logic [BLOCK_LENGTH-1:0] key_q;
  logic [3:0]              cnt;
  logic [3:0]              idx;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    unique case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic        serve;
  logic [31:0] sw_in;
  logic [31:0] rot;
  logic [31:0] sw_out;
  logic [31:0] t;

  // one S-box word serves both directions; the state picks the source
  assign serve  = (state == SERVE);
  assign sw_in  = serve ? (key_q[63:32] ^ key_q[31:0])
                        : key_q[31:0];
  assign rot    = {sw_in[23:0], sw_in[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .y (sw_out[8*g +: 8])
    );
  end

  assign t = sw_out ^ {rcon(serve ? idx : cnt), 24'h0};

  logic [31:0] f0, f1, f2, f3;
  logic [31:0] i0, i1, i2, i3;

  assign f0 = key_q[127:96] ^ t;
  assign f1 = key_q[95:64] ^ f0;
  assign f2 = key_q[63:32] ^ f1;
  assign f3 = key_q[31:0] ^ f2;

  assign i3 = key_q[31:0] ^ key_q[63:32];
  assign i2 = key_q[63:32] ^ key_q[95:64];
  assign i1 = key_q[95:64] ^ key_q[127:96];
  assign i0 = key_q[127:96] ^ t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      key_q   <= '0;
      cnt     <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.key_load) begin
        key_q   <= bus.key;
        cnt     <= 4'd1;
        idx     <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b1;
        state   <= EXPAND;
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          EXPAND: begin
            key_q <= {f0, f1, f2, f3};
            if (cnt == LAST) begin
              idx     <= LAST;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= SERVE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          SERVE: begin
            if (bus.key_next) begin
              if (idx != 4'd0) begin
                key_q <= {i0, i1, i2, i3};
                idx   <= idx - 4'd1;
              end else begin
                valid_q <= 1'b0;
                done_q  <= 1'b1;
                state   <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef AES_EQUIV_INV_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2    = xt(a[k]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // stored key stays raw; only the presented copy is mixed
  assign bus.sub_key = (idx != 4'd0 && idx != LAST)
    ? {imc(key_q[127:96]), imc(key_q[95:64]),
       imc(key_q[63:32]), imc(key_q[31:0])}
    : key_q;
`else
  assign bus.sub_key = key_q;
`endif

  assign bus.round_index = idx;
  assign bus.key_valid   = valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_aes_inv_key_generator.sv
// Bench for aes_inv_key_generator against a forward-schedule model
// built from GF(2^8) arithmetic.
module tb_aes_inv_key_generator;
  logic clk;
  logic rst;

  aes_inv_key_generator_if #(.BLOCK_LENGTH(128)) bus ();

  aes_inv_key_generator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nerr;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b,
                                       input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  logic [7:0] sbt [256];

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
             ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  logic [127:0] rk [11];

  task automatic build(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] imc128(input logic [127:0] s);
    logic [7:0] cf [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        logic [7:0] acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(s[127-32*c-8*j -: 8], cf[(j - r + 4) % 4]);
        o[127-32*c-8*r -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] present(input int r);
`ifdef AES_EQUIV_INV_KEY_EN
    if (r >= 1 && r <= 9) return imc128(rk[r]);
`endif
    return rk[r];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k, input logic nxt);
    bus.key      = k;
    bus.key_load = 1'b1;
    bus.key_next = nxt;
    step();
    bus.key_load = 1'b0;
    bus.key_next = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.key_valid && n < 20) begin
      chk({tag, "_busy"}, 128'(bus.busy), 128'(1));
      chk({tag, "_nodone"}, 128'(bus.done), 128'(0));
      step();
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(10));
    chk({tag, "_busy_off"}, 128'(bus.busy), 128'(0));
  endtask

  task automatic walk(input string tag, input int max_gap);
    for (int r = 10; r >= 0; r--) begin
      int gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      chk({tag, "_idx"}, 128'(bus.round_index), 128'(r));
      chk({tag, "_key"}, bus.sub_key, present(r));
      chk({tag, "_valid"}, 128'(bus.key_valid), 128'(1));
      for (int g = 0; g < gap; g++) begin
        bus.key_next = 1'b0;
        step();
        chk({tag, "_hold"}, 128'(bus.round_index), 128'(r));
      end
      bus.key_next = 1'b1;
      step();
    end
    bus.key_next = 1'b0;
    chk({tag, "_done"}, 128'(bus.done), 128'(1));
    chk({tag, "_vld_off"}, 128'(bus.key_valid), 128'(0));
    chk({tag, "_held"}, bus.sub_key, rk[0]);
    step();
    chk({tag, "_done_pulse"}, 128'(bus.done), 128'(0));
  endtask

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K2R = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    nchk = 0;
    nerr = 0;
    bus.key      = '0;
    bus.key_load = 1'b0;
    bus.key_next = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #5;
    chk("rst_sub_key", bus.sub_key, 128'h0);
    chk("rst_idx", 128'(bus.round_index), 128'h0);
    chk("rst_valid", 128'(bus.key_valid), 128'h0);
    chk("rst_busy", 128'(bus.busy), 128'h0);
    chk("rst_done", 128'(bus.done), 128'h0);
    step();
    rst = 1'b1;
    step();

    build(K1);
    chk("model_r10", rk[10], R10);
    chk("model_r9", rk[9], R9);
    load(K1, 1'b0);
    wait_valid("start");
    chk("start_idx", 128'(bus.round_index), 128'd10);
    chk("start_key", bus.sub_key, R10);
    bus.key_next = 1'b1;
    step();
    bus.key_next = 1'b0;
    chk("back_idx", 128'(bus.round_index), 128'd9);
    chk("back_key", bus.sub_key, present(9));
`ifndef AES_EQUIV_INV_KEY_EN
    chk("back_key_raw", bus.sub_key, R9);
`endif

    load(K1, 1'b0);
    wait_valid("walk");
    walk("walk", 0);
    chk("walk_r0_raw", bus.sub_key, K1);

    bus.key_next = 1'b1;
    step();
    step();
    bus.key_next = 1'b0;
    chk("idle_ign_valid", 128'(bus.key_valid), 128'h0);
    chk("idle_ign_idx", 128'(bus.round_index), 128'h0);

    load(K1, 1'b0);
    wait_valid("pre_abort");
    for (int i = 0; i < 5; i++) begin
      bus.key_next = 1'b1;
      step();
    end
    bus.key_next = 1'b0;
    chk("abort_at5", 128'(bus.round_index), 128'd5);
    build(K2);
    chk("model_k2", rk[10], K2R);
    load(K2, 1'b1);
    chk("abort_valid", 128'(bus.key_valid), 128'h0);
    chk("abort_done", 128'(bus.done), 128'h0);
    wait_valid("abort");
    chk("abort_idx", 128'(bus.round_index), 128'd10);
    chk("abort_key", bus.sub_key, K2R);
    walk("abort_walk", 1);

    load(K1, 1'b0);
    step();
    step();
    step();
    #3 rst = 1'b0;
    #1;
    chk("arst_sub_key", bus.sub_key, 128'h0);
    chk("arst_idx", 128'(bus.round_index), 128'h0);
    chk("arst_valid", 128'(bus.key_valid), 128'h0);
    chk("arst_busy", 128'(bus.busy), 128'h0);
    step();
    rst = 1'b1;
    bus.key_next = 1'b1;
    for (int i = 0; i < 12; i++) step();
    bus.key_next = 1'b0;
    chk("arst_ign_valid", 128'(bus.key_valid), 128'h0);
    chk("arst_ign_busy", 128'(bus.busy), 128'h0);
    chk("arst_ign_idx", 128'(bus.round_index), 128'h0);
    build(K1);
    load(K1, 1'b0);
    wait_valid("arst_reload");
    chk("arst_reload_key", bus.sub_key, R10);

    for (int t = 0; t < 4; t++) begin
      logic [127:0] k;
      k = {$urandom, $urandom, $urandom, $urandom};
      build(k);
      load(k, 1'b0);
      wait_valid("rnd");
      walk("rnd", 2);
      chk("rnd_r0", bus.sub_key, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
